// File: rtl/bt_status_tx.sv
// bt_status_tx: UART status reporter for the Bluetooth return path.
// Sends A5,{state,life},{miss,score},xor on input change and after reset.
module bt_status_tx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int GAP_BITS     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic [3:0] score,
  input  logic [3:0] miss,
  input  logic [1:0] life,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int BW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GW =
    (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [BW-1:0] BAUD_LAST =
    BW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    GAP
  } fsm_t;

  fsm_t fsm_q, fsm_d;

  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      byte_q, byte_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [3:0][7:0] buf_q;
  logic [12:0]     prev_q;
  logic            pending_q;

  logic [12:0] cur;
  logic        change;
  logic        launch;
  logic        bit_end;
  logic [7:0]  b1;
  logic [7:0]  b2;
  logic [7:0]  cur_byte;
  logic        tx_d;
  logic        busy_d;
  logic        done_d;

  assign cur     = {state, score, miss, life};
  assign change  = cur != prev_q;
  assign launch  = (fsm_q == IDLE) && pending_q;
  assign bit_end = baud_q == BAUD_LAST;
  assign b1      = {state, life, 3'b000};
  assign b2      = {miss, score};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q  <= IDLE;
      baud_q <= '0;
      bit_q  <= '0;
      byte_q <= '0;
      gap_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      baud_q <= baud_d;
      bit_q  <= bit_d;
      byte_q <= byte_d;
      gap_q  <= gap_d;
    end
  end

  // A change in the launch cycle keeps pending set: one more frame follows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q      <= '0;
      prev_q     <= '0;
      pending_q  <= 1'b1;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      prev_q     <= cur;
      pending_q  <= change | (pending_q & ~launch);
      tx         <= tx_d;
      busy       <= busy_d;
      frame_done <= done_d;
      if (launch) begin
        buf_q <= {8'hA5 ^ b1 ^ b2, b2, b1, 8'hA5};
      end
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    baud_d = baud_q + BW'(1);
    bit_d  = bit_q;
    byte_d = byte_q;
    gap_d  = gap_q;
    done_d = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        baud_d = '0;
        if (launch) begin
          fsm_d  = START;
          byte_d = '0;
          bit_d  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          fsm_d  = DATA;
          baud_d = '0;
          bit_d  = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            fsm_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (byte_q != 2'd3) begin
            byte_d = byte_q + 2'd1;
            fsm_d  = START;
          end else if (GAP_BITS == 0) begin
            fsm_d  = IDLE;
            done_d = 1'b1;
          end else begin
            fsm_d = GAP;
            gap_d = '0;
          end
        end
      end
      GAP: begin
        if (bit_end) begin
          baud_d = '0;
          if (gap_q == GAP_LAST) begin
            fsm_d  = IDLE;
            done_d = 1'b1;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they stay registered.
  always_comb begin
    cur_byte = buf_q[byte_d];
    busy_d   = fsm_d != IDLE;
    tx_d     = 1'b1;
    unique case (1'b1)
      (fsm_d == START): tx_d = 1'b0;
      (fsm_d == DATA):  tx_d = cur_byte[bit_d];
      default:          tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_bt_status_tx.sv
// tb_bt_status_tx: table vectors plus frame scoreboard for bt_status_tx.
// A second instance with GAP_BITS=0 covers back-to-back frames.
module tb_bt_status_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] state, state0;
  logic [3:0] score, miss, score0, miss0;
  logic [1:0] life, life0;
  logic       tx, busy, frame_done;
  logic       tx0, busy0, frame_done0;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  st;
    logic [3:0]  sc;
    logic [3:0]  mi;
    logic [1:0]  li;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];

  bt_status_tx #(
    .CLKS_PER_BIT(CPB),
    .GAP_BITS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .state(state),
    .score(score),
    .miss(miss),
    .life(life),
    .tx(tx),
    .busy(busy),
    .frame_done(frame_done)
  );

  bt_status_tx #(
    .CLKS_PER_BIT(CPB),
    .GAP_BITS(0)
  ) dut0 (
    .clk(clk),
    .rst(rst),
    .state(state0),
    .score(score0),
    .miss(miss0),
    .life(life0),
    .tx(tx0),
    .busy(busy0),
    .frame_done(frame_done0)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h",
               nm, got, want);
    end
  endtask

  task automatic drive(input logic [2:0] st,
                       input logic [3:0] sc,
                       input logic [3:0] mi,
                       input logic [1:0] li);
    state = st;
    score = sc;
    miss  = mi;
    life  = li;
  endtask

  task automatic wait_fd(input int lim,
                         input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!frame_done && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, frame_done, 1);
  endtask

  task automatic wait_fall(input int lim,
                           input string nm);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, tx, 0);
  endtask

  task automatic idle_chk(input int len,
                          input string nm);
    int n;
    n = 0;
    repeat (len) begin
      @(negedge clk);
      n += int'(busy);
    end
    chk(nm, n, 0);
  endtask

  // UART monitor: mid-bit sampling, 4 bytes per frame, scoreboard pop.
  initial begin
    logic [9:0]  bits;
    logic [31:0] got;
    logic        ferr;
    logic [31:0] want;
    int          nb;
    bit          ok;
    nb   = 0;
    got  = '0;
    ferr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        nb   = 0;
        ferr = 1'b0;
      end else if (tx == 1'b0) begin
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
          repeat (k == 0 ? CPB / 2 : CPB) @(negedge clk);
          if (!rst) begin
            ok = 1'b0;
            break;
          end
          bits[k] = tx;
        end
        if (!ok) begin
          nb   = 0;
          ferr = 1'b0;
        end else begin
          ferr = ferr | bits[0] | ~bits[9];
          got  = {got[23:0], bits[8:1]};
          nb++;
          if (nb == 4) begin
            chk("sb_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
              want = exp_q.pop_front();
              chk("frame", {ferr, got}, {1'b0, want});
            end
            nb   = 0;
            ferr = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int n;
    logic [161:0] vtx, vb, vfd;
    bit stop_ok;

    vecs[0] = '{3'd2, 4'd5,  4'd2,  2'd3, 32'hA5_58_25_D8};
    vecs[1] = '{3'd7, 4'd15, 4'd15, 2'd0, 32'hA5_E0_FF_BA};
    vecs[2] = '{3'd1, 4'd0,  4'd9,  2'd1, 32'hA5_28_90_1D};
    vecs[3] = '{3'd4, 4'd10, 4'd3,  2'd2, 32'hA5_90_3A_0F};
    vecs[4] = '{3'd5, 4'd3,  4'd12, 2'd1, 32'hA5_A8_C3_CE};

    drive(3'd0, 4'd0, 4'd0, 2'd0);
    state0 = 3'd0;
    score0 = 4'd0;
    miss0  = 4'd0;
    life0  = 2'd0;
    repeat (3) @(negedge clk);

    // boot frame
    chk("reset", {tx, busy, frame_done}, 3'b100);
    exp_q.push_back(32'hA5_00_00_A5);
    rst = 1'b1;
    @(negedge clk);
    chk("launch_lat", {tx, busy}, 2'b01);
    n = 0;
    while (busy && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk("frame_len", n, 168);
    chk("fd_at_end", {frame_done, busy}, 2'b10);
    @(negedge clk);
    chk("fd_one_cycle", frame_done, 0);
    idle_chk(200, "boot_no_extra");

    // table vectors
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].st, vecs[i].sc,
            vecs[i].mi, vecs[i].li);
      exp_q.push_back(vecs[i].exp);
      wait_fd(400, "tbl_done");
      repeat (3) @(negedge clk);
    end

    // coalesced mid-frame changes
    drive(3'd2, 4'd5, 4'd2, 2'd3);
    exp_q.push_back(32'hA5_58_25_D8);
    wait_fall(20, "t3_start");
    repeat (30) @(negedge clk);
    score = 4'd6;
    repeat (30) @(negedge clk);
    score = 4'd7;
    exp_q.push_back(32'hA5_58_27_DA);
    wait_fd(400, "t3_first");
    chk("t3_gap", busy, 0);
    @(negedge clk);
    chk("t3_relaunch", {tx, busy}, 2'b01);
    wait_fd(400, "t3_second");
    idle_chk(100, "t3_no_extra");

    // change on the launch cycle
    drive(3'd7, 4'd15, 4'd15, 2'd0);
    exp_q.push_back(32'hA5_E0_FF_BA);
    wait_fall(20, "t4_start");
    repeat (40) @(negedge clk);
    drive(3'd1, 4'd0, 4'd9, 2'd1);
    wait_fd(400, "t4_first");
    drive(3'd4, 4'd10, 4'd3, 2'd2);
    exp_q.push_back(32'hA5_90_3A_0F);
    exp_q.push_back(32'hA5_90_3A_0F);
    wait_fd(400, "t4_second");
    wait_fd(400, "t4_third");
    idle_chk(100, "t4_no_extra");

    // reset mid-frame
    drive(3'd5, 4'd3, 4'd12, 2'd1);
    exp_q.push_back(32'hA5_A8_C3_CE);
    wait_fall(20, "t5_start");
    repeat (49) @(negedge clk);
    chk("t5_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1 chk("rst_abort", {tx, busy, frame_done}, 3'b100);
    exp_q.delete();
    drive(3'd0, 4'd0, 4'd0, 2'd0);
    n = 0;
    repeat (3) begin
      @(negedge clk);
      n += int'(frame_done);
    end
    chk("rst_no_fd", n, 0);
    rst = 1'b1;
    exp_q.push_back(32'hA5_00_00_A5);
    @(negedge clk);
    chk("t5_relaunch", {tx, busy}, 2'b01);
    wait_fd(400, "t5_boot");
    idle_chk(100, "t5_no_extra");

    // back-to-back frames with no gap
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          repeat (100) @(negedge clk);
          score0 = score0 + 4'd1;
        end
      end
      begin
        n = 0;
        while (tx0 !== 1'b0 && n < 300) begin
          @(negedge clk);
          n++;
        end
        chk("t6_start", tx0, 0);
        for (int f = 0; f < 4; f++) begin
          vtx[0] = tx0;
          vb[0]  = busy0;
          vfd[0] = frame_done0;
          for (int o = 1; o < 162; o++) begin
            @(negedge clk);
            vtx[o] = tx0;
            vb[o]  = busy0;
            vfd[o] = frame_done0;
          end
          stop_ok = 1'b1;
          for (int j = 0; j < 4; j++) begin
            for (int b = 36; b < 40; b++) begin
              if (!vtx[40 * j + b]) stop_ok = 1'b0;
            end
            if (j < 3 && vtx[40 * j + 40]) begin
              stop_ok = 1'b0;
            end
          end
          chk("t6_stop", stop_ok, 1);
          chk("t6_busy", vb[159:0], {160{1'b1}});
          chk("t6_gap",
              {vb[160], vfd[160], vtx[160],
               vtx[161], vb[161]},
              5'b01101);
        end
      end
    join

    repeat (200) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
